temporal_ngram_bundler: RTL and testbench
=========================================

Name: temporal_ngram_bundler

Overview:
Upstream feeder of the associative memory stage. Takes a stream of spatially encoded hypervectors (one per sample) and forms temporal N-grams by permute-and-XOR over a sliding history. It bundles BUNDLE_COUNT consecutive N-grams by per-bit majority and presents the result as the query hypervector on a valid/ready interface. Its output drives the associative memory's HypervectorIn_DI / ValidIn_SI / ReadyOut_SO directly.

Parameters:
HV_DIMENSION, 2000, hypervector width in bits; must equal the const.vh value in the integrated design.
NGRAM_SIZE, 3, N-gram length, >=1; history depth is NGRAM_SIZE-1.
BUNDLE_COUNT, 5, N-grams bundled per output hypervector, >=1; odd values give a strict majority.
CNT_WIDTH, ceilLog2(BUNDLE_COUNT+1), width of the per-bit and N-gram counters; derived, not overridden.

Ports:
Clk_CI  in  1  clock, rising edge
Reset_RI  in  1  reset, asynchronous, active-high
ValidIn_SI  in  1  upstream spatial hypervector valid
ReadyOut_SO  out  1  block accepts an input this cycle
HypervectorIn_DI  in  [0:HV_DIMENSION-1]  spatial hypervector
ValidOut_SO  out  1  bundled hypervector valid
ReadyIn_SI  in  1  downstream (associative memory) ready
HypervectorOut_DO  out  [0:HV_DIMENSION-1]  bundled query hypervector, registered

Behaviour:
- Reset values: state ACCUM; history, warm-up counter, N-gram counter and all bit counters = 0; HypervectorOut_DO = 0; ValidOut_SO = 0.
- ReadyOut_SO = (state==ACCUM) && !Reset_RI. This is the only combinational output.
- Accept = ValidIn_SI && ReadyOut_SO.
- Permutation rho(x)[i] = x[(i-1) mod D]: rotate by one toward higher index, so bit D-1 wraps to bit 0. rho^k applies rho k times.
- History H[0..NGRAM_SIZE-2], with H[0] = most recent prior input. On Accept, the history shifts: H[0] <= input, H[k] <= H[k-1].
- N-gram = input XOR rho(H[0]) XOR rho^2(H[1]) ... XOR rho^(NGRAM_SIZE-1)(H[NGRAM_SIZE-2]). When NGRAM_SIZE=1, the N-gram is the input itself.
- Warm-up: the first NGRAM_SIZE-1 Accepts after reset only fill the history and are not counted.
- History persists across bundles, giving a sliding window. Warm-up happens only once per reset.
- Counting: each counted Accept adds the N-gram bits to the per-bit counters and increments the N-gram counter.
- FSM:
  - ACCUM: stays in ACCUM until the Accept that brings the N-gram count to BUNDLE_COUNT. On that edge:
    - HypervectorOut_DO[i] <= (2*cnt_next[i] > BUNDLE_COUNT), where cnt_next includes the current N-gram. Ties resolve to 0.
    - Counters clear to 0.
    - State -> OUTPUT.
  - OUTPUT: ValidOut_SO=1. HypervectorOut_DO is held stable. No input is accepted. On ReadyIn_SI=1 the state goes to ACCUM on the next edge, with ValidOut_SO=0 that cycle.
- Latency: ValidOut_SO rises on the cycle after the final counting Accept.
- Throughput: one input per cycle in ACCUM. There is one bubble cycle per bundle for the output handshake.
- Counters cannot overflow, because the maximum count is BUNDLE_COUNT.
- ValidIn_SI while in OUTPUT: ignored, no state change. Upstream must hold its data.
- HypervectorIn_DI while ValidIn_SI=0: don't-care.
- Asynchronous reset mid-operation (any state) immediately clears all state and outputs. Warm-up restarts afterwards.

Test Plan:
- Reset: assert Reset_RI mid-cycle -> ValidOut_SO=0, HypervectorOut_DO=0, ReadyOut_SO=0 immediately; after release ReadyOut_SO=1.
- Config D=8, NGRAM_SIZE=3, BUNDLE_COUNT=3: feed 5 inputs of bit0-only (8'b1000_0000) -> first 2 uncounted; N-gram = 8'b1110_0000. ValidOut_SO rises the cycle after the 5th Accept with HypervectorOut_DO=8'b1110_0000.
- Config NGRAM_SIZE=1, BUNDLE_COUNT=3: inputs 8'b1111_0000, 8'b1100_1100, 8'b1010_1010 -> output 8'b1110_1000.
- Backpressure: hold ReadyIn_SI=0 for 10 cycles while ValidIn_SI toggles -> ValidOut_SO=1, output constant, ReadyOut_SO=0, no Accepts. Raise ReadyIn_SI -> next cycle ValidOut_SO=0, ReadyOut_SO=1.
- Sliding history (D=8, N=3, B=3): after the first bundle, the next output appears after exactly 3 further Accepts with no warm-up. Check against a reference model.
- Tie, BUNDLE_COUNT=2 with NGRAM_SIZE=1: inputs 8'hFF, 8'h00 -> output 8'h00. Async reset after 2 Accepts of a bundle -> the next output needs the full warm-up plus BUNDLE_COUNT inputs.

Source files
------------

// File: rtl/temporal_ngram_bundler.sv
// Temporal N-gram former and majority bundler feeding the associative memory.
// Builds permute-and-XOR N-grams over a sliding history and bundles BUNDLE_COUNT of them.
module temporal_ngram_bundler #(
    parameter int unsigned HV_DIMENSION = 2000,
    parameter int unsigned NGRAM_SIZE   = 3,
    parameter int unsigned BUNDLE_COUNT = 5
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO
);

    localparam int unsigned CNT_WIDTH  = $clog2(BUNDLE_COUNT + 1);
    localparam int unsigned MAJ_W      = CNT_WIDTH + 1;
    localparam int unsigned HIST_DEPTH = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;
    localparam int unsigned WARM_W     = $clog2(NGRAM_SIZE + 1);

    typedef enum logic {
        S_ACCUM  = 1'b0,
        S_OUTPUT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_valid;
    logic                    w_valid_next;
    logic [0:HV_DIMENSION-1] r_hv_out;

    logic                    w_accept;
    logic                    w_warm_done;
    logic                    w_count;
    logic                    w_last;
    logic [0:HV_DIMENSION-1] w_ngram;
    logic [0:HV_DIMENSION-1] w_major;

    logic [CNT_WIDTH-1:0]    r_ngram_cnt;
    logic [CNT_WIDTH-1:0]    r_cnt      [HV_DIMENSION];
    logic [CNT_WIDTH-1:0]    w_cnt_next [HV_DIMENSION];

    assign ReadyOut_SO       = (r_state == S_ACCUM) && !Reset_RI;
    assign ValidOut_SO       = r_valid;
    assign HypervectorOut_DO = r_hv_out;

    assign w_accept = ValidIn_SI && ReadyOut_SO;
    assign w_count  = w_accept && w_warm_done;
    assign w_last   = w_count && (r_ngram_cnt == CNT_WIDTH'(BUNDLE_COUNT - 1));

    // History shift register, warm-up counter and N-gram formation
    if (NGRAM_SIZE > 1) begin : g_hist
        logic [0:HV_DIMENSION-1] r_hist [HIST_DEPTH];
        logic [WARM_W-1:0]       r_warm;
        logic [0:HV_DIMENSION-1] w_term;

        always_ff @(posedge Clk_CI or posedge Reset_RI) begin
            if (Reset_RI) begin
                for (int k = 0; k < int'(HIST_DEPTH); k++) begin
                    r_hist[k] <= '0;
                end
                r_warm <= '0;
            end else if (w_accept) begin
                r_hist[0] <= HypervectorIn_DI;
                for (int k = 1; k < int'(HIST_DEPTH); k++) begin
                    r_hist[k] <= r_hist[k-1];
                end
                if (!w_warm_done) begin
                    r_warm <= r_warm + WARM_W'(1);
                end
            end
        end

        assign w_warm_done = (r_warm == WARM_W'(NGRAM_SIZE - 1));

        // H[k] is rotated k+1 places toward higher index before XOR
        always_comb begin
            w_ngram = HypervectorIn_DI;
            w_term  = '0;
            for (int k = 0; k < int'(HIST_DEPTH); k++) begin
                w_term = r_hist[k];
                for (int r = 0; r <= k; r++) begin
                    w_term = {w_term[HV_DIMENSION-1], w_term[0:HV_DIMENSION-2]};
                end
                w_ngram = w_ngram ^ w_term;
            end
        end
    end else begin : g_no_hist
        assign w_warm_done = 1'b1;
        assign w_ngram     = HypervectorIn_DI;
    end

    // Per-bit count including the current N-gram, and strict-majority threshold
    always_comb begin
        for (int i = 0; i < int'(HV_DIMENSION); i++) begin
            w_cnt_next[i] = r_cnt[i] + CNT_WIDTH'(w_ngram[i]);
            w_major[i]    = ({w_cnt_next[i], 1'b0} > MAJ_W'(BUNDLE_COUNT));
        end
    end

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            for (int i = 0; i < int'(HV_DIMENSION); i++) begin
                r_cnt[i] <= '0;
            end
            r_ngram_cnt <= '0;
        end else if (w_last) begin
            for (int i = 0; i < int'(HV_DIMENSION); i++) begin
                r_cnt[i] <= '0;
            end
            r_ngram_cnt <= '0;
        end else if (w_count) begin
            for (int i = 0; i < int'(HV_DIMENSION); i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            r_ngram_cnt <= r_ngram_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            r_hv_out <= '0;
        end else if (w_last) begin
            r_hv_out <= w_major;
        end
    end

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            r_state <= S_ACCUM;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_valid_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_valid_next = 1'b0;
        case (r_state)
            S_ACCUM: begin
                if (w_last) begin
                    w_state_next = S_OUTPUT;
                    w_valid_next = 1'b1;
                end
            end
            S_OUTPUT: begin
                if (ReadyIn_SI) begin
                    w_state_next = S_ACCUM;
                end else begin
                    w_valid_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_ACCUM;
            end
        endcase
    end

endmodule

// File: tb/tb_temporal_ngram_bundler.sv
// Directed bench for temporal_ngram_bundler: three D=8 instances (N3/B3, N1/B3, N1/B2)
// checked against a scoreboard fed by a behavioural N-gram/majority model.
module tb_temporal_ngram_bundler;

    logic       clk;
    logic       rst;
    logic       vin     [3];
    logic       rdy_out [3];
    logic       vout    [3];
    logic       rin     [3];
    logic [0:7] din     [3];
    logic [0:7] dout    [3];

    int n_assert = 0;
    int n_fail   = 0;

    logic [0:7] exp_q[$];
    logic [0:7] held;

    // Reference model state for instance 0 (N=3, B=3)
    logic [0:7] mh0, mh1;
    int         mwarm, mn;
    int         mc [8];

    temporal_ngram_bundler #(.HV_DIMENSION(8), .NGRAM_SIZE(3), .BUNDLE_COUNT(3)) u0 (
        .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(vin[0]), .ReadyOut_SO(rdy_out[0]),
        .HypervectorIn_DI(din[0]), .ValidOut_SO(vout[0]), .ReadyIn_SI(rin[0]),
        .HypervectorOut_DO(dout[0]));

    temporal_ngram_bundler #(.HV_DIMENSION(8), .NGRAM_SIZE(1), .BUNDLE_COUNT(3)) u1 (
        .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(vin[1]), .ReadyOut_SO(rdy_out[1]),
        .HypervectorIn_DI(din[1]), .ValidOut_SO(vout[1]), .ReadyIn_SI(rin[1]),
        .HypervectorOut_DO(dout[1]));

    temporal_ngram_bundler #(.HV_DIMENSION(8), .NGRAM_SIZE(1), .BUNDLE_COUNT(2)) u2 (
        .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(vin[2]), .ReadyOut_SO(rdy_out[2]),
        .HypervectorIn_DI(din[2]), .ValidOut_SO(vout[2]), .ReadyIn_SI(rin[2]),
        .HypervectorOut_DO(dout[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:7] rho(input logic [0:7] x);
        logic [0:7] y;
        for (int i = 0; i < 8; i++) y[i] = x[(i + 7) % 8];
        return y;
    endfunction

    task automatic model_reset();
        mh0 = '0; mh1 = '0; mwarm = 0; mn = 0;
        for (int i = 0; i < 8; i++) mc[i] = 0;
    endtask

    task automatic model_accept(input logic [0:7] x);
        logic [0:7] ng;
        logic [0:7] res;
        if (mwarm < 2) begin
            mwarm++;
        end else begin
            ng = x ^ rho(mh0) ^ rho(rho(mh1));
            for (int i = 0; i < 8; i++) mc[i] += int'(ng[i]);
            mn++;
            if (mn == 3) begin
                for (int i = 0; i < 8; i++) begin
                    res[i] = (2 * mc[i] > 3);
                    mc[i]  = 0;
                end
                mn = 0;
                exp_q.push_back(res);
            end
        end
        mh1 = mh0;
        mh0 = x;
    endtask

    // Drive one accepted input on instance idx; block must be ready and idle
    task automatic feed(input int idx, input logic [0:7] x);
        @(negedge clk);
        chk($sformatf("ready_u%0d", idx), 32'(rdy_out[idx]), 32'd1);
        chk($sformatf("no_early_valid_u%0d", idx), 32'(vout[idx]), 32'd0);
        vin[idx] = 1'b1;
        din[idx] = x;
        if (idx == 0) model_accept(x);
    endtask

    task automatic check_out(input int idx, input string tag);
        logic [0:7] e;
        @(negedge clk);
        vin[idx] = 1'b0;
        chk({tag, "_valid"}, 32'(vout[idx]), 32'd1);
        n_assert++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, 32'(dout[idx]), 32'(e));
        end
        held = dout[idx];
    endtask

    task automatic hold_bp(input int idx, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(vout[idx]), 32'd1);
            chk("bp_ready", 32'(rdy_out[idx]), 32'd0);
            chk("bp_hold", 32'(dout[idx]), 32'(held));
            vin[idx] = c[0];
            din[idx] = 8'($urandom);
        end
        vin[idx] = 1'b0;
    endtask

    task automatic release_out(input int idx);
        rin[idx] = 1'b1;
        @(negedge clk);
        rin[idx] = 1'b0;
        chk($sformatf("release_valid_u%0d", idx), 32'(vout[idx]), 32'd0);
        chk($sformatf("release_ready_u%0d", idx), 32'(rdy_out[idx]), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vin[i] = 1'b0; rin[i] = 1'b0; din[i] = '0;
        end
        held = '0;
        model_reset();
        #2;
        chk("rst_valid", 32'(vout[0]), 32'd0);
        chk("rst_data", 32'(dout[0]), 32'd0);
        chk("rst_ready", 32'(rdy_out[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(rdy_out[0]), 32'd1);

        // Warm-up plus one bundle of constant bit0 input
        for (int k = 0; k < 5; k++) feed(0, 8'b1000_0000);
        check_out(0, "bundle1");
        chk("bundle1_literal", 32'(dout[0]), 32'(8'b1110_0000));
        release_out(0);

        // Sliding window with backpressure on the output
        for (int k = 0; k < 3; k++) feed(0, 8'($urandom));
        check_out(0, "slide1");
        hold_bp(0, 10);
        release_out(0);

        for (int k = 0; k < 3; k++) feed(0, 8'($urandom));
        check_out(0, "slide2");
        release_out(0);

        // No history: plain majority of three
        feed(1, 8'b1111_0000);
        feed(1, 8'b1100_1100);
        feed(1, 8'b1010_1010);
        exp_q.push_back(8'b1110_1000);
        check_out(1, "ngram1");
        release_out(1);

        // Even bundle count tie resolves to zero
        feed(2, 8'hFF);
        feed(2, 8'h00);
        exp_q.push_back(8'h00);
        check_out(2, "tie");
        release_out(2);

        // Async reset partway through a bundle restarts warm-up
        feed(0, 8'($urandom));
        feed(0, 8'($urandom));
        @(posedge clk);
        #3;
        vin[0] = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) feed(0, 8'b1000_0000);
        check_out(0, "after_rst");
        chk("after_rst_literal", 32'(dout[0]), 32'(8'b1110_0000));

        // Mid-cycle reset while holding a valid output
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(vout[0]), 32'd0);
        chk("midrst_data", 32'(dout[0]), 32'd0);
        chk("midrst_ready", 32'(rdy_out[0]), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_release_ready", 32'(rdy_out[0]), 32'd1);
        chk("midrst_release_valid", 32'(vout[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
